inst_mem_loader: RTL and testbench

Parametrised, synchronous successor to the combinational instruction memory. It stores halfwords and returns a registered 2-halfword instruction to the fetch stage with one-cycle latency. It accepts 32-bit program words from a loader through a valid/ready handshake, and writes each word as two halfwords over two cycles through a single write port. It sits between the program loader/testbench and the IF stage of the pipelined processor.

---
 rtl/inst_mem_loader.sv | 110 +++++++++++
 tb/tb_inst_mem_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: halfword instruction memory, registered 2-halfword fetch and a
// 3-cycle valid/ready word loader. Define INST_MEM_BYPASS_EN to forward the in-flight word.
module inst_mem_loader #(
  parameter int ADDR_W = 20,
  parameter int HW_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic [2*HW_W-1:0] instruction,
  output logic              fetch_valid,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_addr,
  input  logic [2*HW_W-1:0] ld_data,
  output logic [31:0]       ld_count
);
  localparam int STAGES = 1;
  localparam int NUM_HW = 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef struct packed {
    addr_t             addr;
    logic [2*HW_W-1:0] data;
  } ld_req_t;
  typedef enum logic [1:0] {IDLE, WR_HI, WR_LO} state_t;

  logic [HW_W-1:0] mem [0:(1<<ADDR_W)-1];

  state_t                      state;
  ld_req_t                     cap;
  logic [NUM_HW-1:0][HW_W-1:0] rd_hw;
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:1]             vld_q;
  addr_t                       wr_addr;
  logic [HW_W-1:0]             wr_hw;
  logic                        wr_en;
  logic                        unused_addr_hi;

  assign unused_addr_hi = ^{fetch_addr[31:ADDR_W], ld_addr[31:ADDR_W]};

  // lane 0 reads A (upper half of the instruction), lane 1 reads A+1 with natural wrap
  for (genvar i = 0; i < NUM_HW; i++) begin : g_lane
    addr_t           ra;
    logic [HW_W-1:0] hw;
    assign ra = fetch_addr[ADDR_W-1:0] + addr_t'(i);
`ifdef INST_MEM_BYPASS_EN
    always_comb begin
      hw = mem[ra];
      if (state != IDLE) begin
        if (ra == cap.addr)                   hw = cap.data[2*HW_W-1:HW_W];
        else if (ra == cap.addr + addr_t'(1)) hw = cap.data[HW_W-1:0];
      end
    end
`else
    assign hw = mem[ra];
`endif
    assign rd_hw[i] = hw;
  end

  assign vld_pipe    = {vld_q, fetch_req};
  assign fetch_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= '0;
      vld_q       <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (fetch_req) instruction <= {rd_hw[0], rd_hw[1]};
    end
  end

  // single write port: upper half in WR_HI, lower half in WR_LO; reads see the old value
  assign wr_en   = (state == WR_HI) || (state == WR_LO);
  assign wr_addr = (state == WR_LO) ? cap.addr + addr_t'(1) : cap.addr;
  assign wr_hw   = (state == WR_LO) ? cap.data[HW_W-1:0] : cap.data[2*HW_W-1:HW_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_hw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ld_ready <= 1'b1;
      ld_count <= '0;
      cap      <= '0;
    end else begin
      case (state)
        IDLE: if (ld_valid) begin
          cap      <= '{addr: ld_addr[ADDR_W-1:0], data: ld_data};
          state    <= WR_HI;
          ld_ready <= 1'b0;
        end
        WR_HI: state <= WR_LO;
        WR_LO: begin
          state    <= IDLE;
          ld_ready <= 1'b1;
          ld_count <= ld_count + 32'd1;
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: spec-timed reference model feeding a fetch scoreboard,
// directed test-plan cases and a randomized mixed fetch/load phase.
`timescale 1ns/1ps
module tb_inst_mem_loader;
  localparam int ADDR_W = 20;
  localparam int HW_W   = 16;
  localparam int AMASK  = (1 << ADDR_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req, ld_valid, ld_ready, fetch_valid;
  logic [31:0] fetch_addr, ld_addr, ld_data, instruction, ld_count;

  always #5 clk = ~clk;

  inst_mem_loader #(.ADDR_W(ADDR_W), .HW_W(HW_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .instruction(instruction), .fetch_valid(fetch_valid),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_count(ld_count)
  );

  typedef struct { int stamp; int addr; logic [15:0] val; bit lo; } wr_t;
  typedef struct { int acc; int addr; logic [31:0] d; } ldw_t;
  typedef struct { logic [31:0] v; logic [31:0] m; } exp_t;

  int          n_chk = 0, n_fail = 0;
  logic [15:0] mm [int];
  wr_t         pend[$];
  ldw_t        inflight[$];
  exp_t        sb[$];
  int          acc_edges[$];
  int          e = 0, next_acc = 0;
  logic [31:0] exp_cnt = 0;

  function automatic int wrapa(int a);
    return a & AMASK;
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: memory as a sparse map, each accepted word becomes two timed writes
  always @(posedge clk) begin : model
    exp_t x;
    e++;
    if (!rst_n) begin
      pend.delete(); inflight.delete(); sb.delete();
      exp_cnt = 0; next_acc = 0;
    end else begin
      if (fetch_req) begin
        x.v = 0; x.m = 0;
        for (int h = 0; h < 2; h++) begin
          int a; bit known; logic [15:0] hv;
          a = wrapa(int'(fetch_addr[ADDR_W-1:0]) + h);
          known = mm.exists(a);
          hv = known ? mm[a] : 16'h0;
`ifdef INST_MEM_BYPASS_EN
          foreach (inflight[k])
            if (inflight[k].acc < e && e <= inflight[k].acc + 2) begin
              if (a == inflight[k].addr) begin hv = inflight[k].d[31:16]; known = 1; end
              else if (a == wrapa(inflight[k].addr + 1)) begin hv = inflight[k].d[15:0]; known = 1; end
            end
`endif
          if (known) begin
            if (h == 0) begin x.v[31:16] = hv; x.m[31:16] = 16'hFFFF; end
            else        begin x.v[15:0]  = hv; x.m[15:0]  = 16'hFFFF; end
          end
        end
        sb.push_back(x);
      end
      for (int k = pend.size() - 1; k >= 0; k--)
        if (pend[k].stamp == e) begin
          mm[pend[k].addr] = pend[k].val;
          if (pend[k].lo) exp_cnt++;
          pend.delete(k);
        end
      for (int k = inflight.size() - 1; k >= 0; k--)
        if (inflight[k].acc + 2 <= e) inflight.delete(k);
      if (ld_valid && e >= next_acc) begin
        int a;
        a = int'(ld_addr[ADDR_W-1:0]);
        pend.push_back('{stamp: e + 1, addr: a, val: ld_data[31:16], lo: 1'b0});
        pend.push_back('{stamp: e + 2, addr: wrapa(a + 1), val: ld_data[15:0], lo: 1'b1});
        inflight.push_back('{acc: e, addr: a, d: ld_data});
        next_acc = e + 3;
        acc_edges.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t x;
    if (rst_n) begin
      if (fetch_valid) begin
        if (sb.size() == 0) check("fetch_valid_spurious", fetch_valid, 1'b0);
        else begin
          x = sb.pop_front();
          if (x.m != 0) check("instruction", instruction & x.m, x.v & x.m);
        end
      end else if (sb.size() != 0) begin
        check("fetch_valid_missing", fetch_valid, 1'b1);
        sb.delete();
      end
      check("ld_ready", ld_ready, (e + 1 >= next_acc));
      check("ld_count", ld_count, exp_cnt);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ld_ready && n < 20) begin tick(); n++; end
    check("ld_ready_timeout", ld_ready, 1'b1);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    wait_ready();
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    tick();
    fetch_req = 1'b0;
  endtask

  logic [31:0] words [4];

  initial begin
    fetch_req = 0; fetch_addr = 0; ld_valid = 0; ld_addr = 0; ld_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_instruction", instruction, 32'h0);
    check("rst_fetch_valid", fetch_valid, 1'b0);
    check("rst_ld_ready", ld_ready, 1'b1);
    check("rst_ld_count", ld_count, 32'h0);
    rst_n = 1'b1;
    tick(); tick();

    do_load(32'h10, 32'h12345678);
    check("ld_ready_busy", ld_ready, 1'b0);
    wait_ready();
    check("ld_count_1", ld_count, 32'd1);
    fetch(32'h10);
    check("fetch_10", instruction, 32'h12345678);
    fetch(32'h11);
    check("fetch_11_hi", instruction[31:16], 16'h5678);

    do_load(32'hFFFFF, 32'hAABBCCDD);
    wait_ready();
    fetch(32'h7A5FFFFF);
    check("fetch_wrap", instruction, 32'hAABBCCDD);
    tick();
    check("hold_instr", instruction, 32'hAABBCCDD);
    check("hold_valid", fetch_valid, 1'b0);

    do_load(32'h100, 32'h11112222);
    wait_ready();
    ld_valid = 1'b1; ld_addr = 32'h100; ld_data = 32'h33334444;
    tick();
    ld_valid = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h100;
    tick();
`ifdef INST_MEM_BYPASS_EN
    check("collision_n1", instruction, 32'h33334444);
`else
    check("collision_n1", instruction, 32'h11112222);
`endif
    tick(); tick();
    fetch_req = 1'b0;
    check("collision_n3", instruction, 32'h33334444);

    do_load(32'h200, 32'h0);
    wait_ready();
    ld_valid = 1'b1; ld_addr = 32'h200; ld_data = 32'hDEADBEEF;
    tick();
    ld_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_ld_count", ld_count, 32'h0);
    check("abort_ld_ready", ld_ready, 1'b1);
    fetch(32'h200);
    check("abort_fetch", instruction, 32'hDEAD0000);

    wait_ready();
    acc_edges.delete();
    ld_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      words[k] = $urandom;
      ld_addr = 32'h400 + 32'(2 * k); ld_data = words[k];
      while (!ld_ready && n < 20) begin tick(); n++; end
      tick();
    end
    ld_valid = 1'b0;
    wait_ready();
    check("b2b_ld_count", ld_count, 32'd4);
    for (int k = 1; k < 4; k++)
      check("b2b_accept_gap", acc_edges.size() > k ? acc_edges[k] - acc_edges[k-1] : -1, 3);
    fetch_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fetch_addr = 32'h400 + 32'(2 * k);
      tick();
      check("b2b_readback", instruction, words[k]);
    end
    fetch_req = 1'b0;

    for (int c = 0; c < 400; c++) begin
      logic [31:0] base;
      base = ($urandom % 2) ? 32'h300 : 32'hFFFF8;
      fetch_req  = 1'($urandom % 2);
      fetch_addr = ($urandom & ~32'(AMASK)) | 32'(wrapa(int'(base) + int'($urandom % 12)));
      ld_valid   = ($urandom % 3) == 0;
      ld_addr    = ($urandom & ~32'(AMASK)) | 32'(wrapa(int'(base) + int'($urandom % 12)));
      ld_data    = $urandom;
      tick();
    end
    fetch_req = 1'b0; ld_valid = 1'b0;
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
